onchip_mem_test_master: RTL and testbench

- Avalon-MM master that drives the single-port 128-bit on-chip RAM slave (2048 words, byteenable, clken, fixed read latency, no waitrequest).
- Executes one command at a time: FILL writes a deterministic pattern over an address range; CHECK reads the range back, XOR-accumulates a signature and counts mismatches against the same pattern.
- Used for RAM bring-up and for self-test ahead of Nios boot.

---
 rtl/onchip_mem_test_pkg.sv | 21 ++
 rtl/onchip_mem_test_master_if.sv | 29 ++
 rtl/onchip_mem_rd_tag_pipe.sv | 53 +++++
 rtl/onchip_mem_test_master.sv | 283 ++++++++++++++++++++++++++++
 tb/tb_onchip_mem_test_master.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/onchip_mem_test_pkg.sv
// Shared types and default parameters for the on-chip RAM test master.
package onchip_mem_test_pkg;

  localparam int DEF_ADDR_W = 11;
  localparam int DEF_DATA_W = 128;
  localparam int DEF_RD_LAT = 1;

  typedef enum logic {
    OP_FILL  = 1'b0,
    OP_CHECK = 1'b1
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FILL  = 3'd1,
    S_CHECK = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/onchip_mem_test_master_if.sv
// Avalon-MM bus between the test master and the single-port on-chip RAM.
interface onchip_mem_test_master_if
  import onchip_mem_test_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) ();

  logic [ADDR_W-1:0]   avm_address;
  logic                avm_chipselect;
  logic                avm_write;
  logic [DATA_W/8-1:0] avm_byteenable;
  logic [DATA_W-1:0]   avm_writedata;
  logic                avm_clken;
  logic [DATA_W-1:0]   avm_readdata;

  modport master (
    output avm_address, avm_chipselect, avm_write, avm_byteenable,
           avm_writedata, avm_clken,
    input  avm_readdata
  );

  modport slave (
    input  avm_address, avm_chipselect, avm_write, avm_byteenable,
           avm_writedata, avm_clken,
    output avm_readdata
  );

endinterface

// File: rtl/onchip_mem_rd_tag_pipe.sv
// Read tag pipeline: carries {valid, index} of each issued read for RD_LAT
// cycles so the returning data can be matched with its expected word.
module onchip_mem_rd_tag_pipe #(
  parameter int IDX_W  = 12,
  parameter int RD_LAT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_valid,
  input  logic [IDX_W-1:0] push_idx,
  output logic             empty,
  output logic             ret_valid,
  output logic [IDX_W-1:0] ret_idx
);

  logic [RD_LAT-1:0]            vld_q, vld_d;
  logic [RD_LAT-1:0][IDX_W-1:0] idx_q, idx_d;

  // Shift a new tag in at stage 0 and advance every older tag by one stage.
  always_comb begin
    vld_d    = vld_q;
    idx_d    = idx_q;
    vld_d[0] = push_valid;
    idx_d[0] = push_idx;
    for (int i = 1; i < RD_LAT; i++) begin
      vld_d[i] = vld_q[i-1];
      idx_d[i] = idx_q[i-1];
    end
  end

  // Pipeline registers; reset drops every outstanding tag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_q <= {RD_LAT{1'b0}};
      idx_q <= {(RD_LAT*IDX_W){1'b0}};
    end else begin
      vld_q <= vld_d;
      idx_q <= idx_d;
    end
  end

  // Empty once the tag returning this cycle retires: no younger stage holds one.
  always_comb begin
    empty = 1'b1;
    for (int i = 0; i < RD_LAT - 1; i++) begin
      empty = empty & ~vld_q[i];
    end
  end

  assign ret_valid = vld_q[RD_LAT-1];
  assign ret_idx   = idx_q[RD_LAT-1];

endmodule

// File: rtl/onchip_mem_test_master.sv
// On-chip RAM test master: FILL writes pattern+i over a wrapping address
// range, CHECK reads it back, XOR-accumulates a signature and counts
// mismatching words. Optional macro ONCHIP_MASTER_BYTEMASK_EN applies the
// command byte mask to FILL writes and CHECK comparisons.
module onchip_mem_test_master
  import onchip_mem_test_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int RD_LAT = DEF_RD_LAT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_op,
  input  logic [ADDR_W-1:0]      cmd_addr,
  input  logic [ADDR_W:0]        cmd_len,
  input  logic [DATA_W-1:0]      cmd_pattern,
  input  logic [DATA_W/8-1:0]    cmd_byteen,
  onchip_mem_test_master_if.master avm,
  output logic                   busy,
  output logic                   done,
  output logic [DATA_W-1:0]      signature,
  output logic [ADDR_W:0]        mismatch_cnt,
  output logic [ADDR_W-1:0]      first_err_addr
);

  localparam int BE_W = DATA_W / 8;
  localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   CNT_MAX  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   CNT_ZERO = {(ADDR_W+1){1'b0}};
  localparam logic [ADDR_W-1:0] ADR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [DATA_W-1:0] DAT_ONE  = {{(DATA_W-1){1'b0}}, 1'b1};

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [ADDR_W:0]     len_q, len_d;
  logic [DATA_W-1:0]   pat_q, pat_d;
  logic [ADDR_W:0]     idx_q, idx_d;
  logic                cs_q, cs_d;
  logic                wr_q, wr_d;
  logic [ADDR_W-1:0]   address_q, address_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [BE_W-1:0]     be_q, be_d;
  logic                clken_q;
  logic                ready_q, ready_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [DATA_W-1:0]   sig_q, sig_d;
  logic [ADDR_W:0]     mcnt_q, mcnt_d;
  logic [ADDR_W-1:0]   ferr_q, ferr_d;

  op_e                 op_s;
  logic                push_s;
  logic                tag_empty_s;
  logic                ret_valid_s;
  logic [ADDR_W:0]     ret_idx_s;
  logic [DATA_W-1:0]   exp_s;
  logic [DATA_W-1:0]   cmp_mask_s;
  logic [BE_W-1:0]     fill_be_s;
  logic                mism_s;

  assign op_s   = op_e'(cmd_op);
  assign push_s = (state_q == S_CHECK);

  onchip_mem_rd_tag_pipe #(
    .IDX_W (ADDR_W + 1),
    .RD_LAT(RD_LAT)
  ) u_tag_pipe (
    .clk       (clk),
    .reset     (reset),
    .push_valid(push_s),
    .push_idx  (idx_q),
    .empty     (tag_empty_s),
    .ret_valid (ret_valid_s),
    .ret_idx   (ret_idx_s)
  );

`ifdef ONCHIP_MASTER_BYTEMASK_EN
  logic [BE_W-1:0] byteen_q, byteen_d;

  // Expand the latched byte mask to a bit mask for the read comparison.
  always_comb begin
    cmp_mask_s = {DATA_W{1'b0}};
    for (int b = 0; b < BE_W; b++) begin
      cmp_mask_s[b*8 +: 8] = {8{byteen_q[b]}};
    end
  end

  assign fill_be_s = cmd_byteen;
  assign byteen_d  = (state_q == S_IDLE && cmd_valid) ? cmd_byteen : byteen_q;

  // Latched byte mask for the running command.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byteen_q <= {BE_W{1'b1}};
    end else begin
      byteen_q <= byteen_d;
    end
  end
`else
  logic unused_byteen_s;

  assign unused_byteen_s = ^cmd_byteen;
  assign cmp_mask_s      = {DATA_W{1'b1}};
  assign fill_be_s       = {BE_W{1'b1}};
`endif

  assign exp_s  = pat_q + DATA_W'(ret_idx_s);
  assign mism_s = ((avm.avm_readdata ^ exp_s) & cmp_mask_s) != {DATA_W{1'b0}};

  // Next-state logic: command acceptance, bus sequencing and read-return status.
  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    len_d     = len_q;
    pat_d     = pat_q;
    idx_d     = idx_q;
    cs_d      = cs_q;
    wr_d      = wr_q;
    address_d = address_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    done_d    = 1'b0;
    sig_d     = sig_q;
    mcnt_d    = mcnt_q;
    ferr_d    = ferr_q;

    // A return and an issue can coincide; both are handled in the same cycle.
    if (ret_valid_s) begin
      sig_d = sig_q ^ avm.avm_readdata;
      if (mism_s) begin
        if (mcnt_q == CNT_ZERO) begin
          ferr_d = base_q + ret_idx_s[ADDR_W-1:0];
        end else begin
          ferr_d = ferr_q;
        end
        if (mcnt_q != CNT_MAX) begin
          mcnt_d = mcnt_q + CNT_ONE;
        end else begin
          mcnt_d = mcnt_q;
        end
      end else begin
        mcnt_d = mcnt_q;
      end
    end else begin
      sig_d = sig_q;
    end

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          base_d    = cmd_addr;
          len_d     = cmd_len;
          pat_d     = cmd_pattern;
          idx_d     = CNT_ZERO;
          address_d = cmd_addr;
          wdata_d   = cmd_pattern;
          if (op_s == OP_CHECK) begin
            sig_d  = {DATA_W{1'b0}};
            mcnt_d = CNT_ZERO;
            ferr_d = {ADDR_W{1'b0}};
          end else begin
            sig_d = sig_q;
          end
          if (cmd_len == CNT_ZERO) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else if (op_s == OP_FILL) begin
            state_d = S_FILL;
            cs_d    = 1'b1;
            wr_d    = 1'b1;
            be_d    = fill_be_s;
          end else begin
            state_d = S_CHECK;
            cs_d    = 1'b1;
            wr_d    = 1'b0;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FILL: begin
        if (idx_q + CNT_ONE == len_q) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          cs_d    = 1'b0;
          wr_d    = 1'b0;
          be_d    = {BE_W{1'b1}};
        end else begin
          idx_d     = idx_q + CNT_ONE;
          address_d = address_q + ADR_ONE;
          wdata_d   = wdata_q + DAT_ONE;
        end
      end
      S_CHECK: begin
        if (idx_q + CNT_ONE == len_q) begin
          state_d = S_DRAIN;
          cs_d    = 1'b0;
        end else begin
          idx_d     = idx_q + CNT_ONE;
          address_d = address_q + ADR_ONE;
        end
      end
      S_DRAIN: begin
        if (tag_empty_s) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cs_d    = 1'b0;
        wr_d    = 1'b0;
        be_d    = {BE_W{1'b1}};
      end
    endcase

    ready_d = (state_d == S_IDLE);
    busy_d  = (state_d != S_IDLE);
  end

  // State and registered outputs; reset aborts any command at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      base_q    <= {ADDR_W{1'b0}};
      len_q     <= CNT_ZERO;
      pat_q     <= {DATA_W{1'b0}};
      idx_q     <= CNT_ZERO;
      cs_q      <= 1'b0;
      wr_q      <= 1'b0;
      address_q <= {ADDR_W{1'b0}};
      wdata_q   <= {DATA_W{1'b0}};
      be_q      <= {BE_W{1'b1}};
      clken_q   <= 1'b1;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      sig_q     <= {DATA_W{1'b0}};
      mcnt_q    <= CNT_ZERO;
      ferr_q    <= {ADDR_W{1'b0}};
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      len_q     <= len_d;
      pat_q     <= pat_d;
      idx_q     <= idx_d;
      cs_q      <= cs_d;
      wr_q      <= wr_d;
      address_q <= address_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
      clken_q   <= 1'b1;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      sig_q     <= sig_d;
      mcnt_q    <= mcnt_d;
      ferr_q    <= ferr_d;
    end
  end

  assign cmd_ready          = ready_q;
  assign busy               = busy_q;
  assign done               = done_q;
  assign signature          = sig_q;
  assign mismatch_cnt       = mcnt_q;
  assign first_err_addr     = ferr_q;
  assign avm.avm_address    = address_q;
  assign avm.avm_chipselect = cs_q;
  assign avm.avm_write      = wr_q;
  assign avm.avm_byteenable = be_q;
  assign avm.avm_writedata  = wdata_q;
  assign avm.avm_clken      = clken_q;

endmodule

// File: tb/tb_onchip_mem_test_master.sv
// Bench for onchip_mem_test_master: two instances (read latency 1 and 2)
// share the command inputs, each with its own RAM model; results are
// compared against a word-level reference of the RAM contents.
`timescale 1ns/1ps
module tb_onchip_mem_test_master;

  localparam int ADDR_W = 11;
  localparam int DATA_W = 128;
  localparam int NW     = 2048;
  localparam int RING   = 4096;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic         cmd_valid = 1'b0;
  logic         cmd_op = 1'b0;
  logic [10:0]  cmd_addr = 11'd0;
  logic [11:0]  cmd_len = 12'd0;
  logic [127:0] cmd_pattern = 128'd0;
  logic [15:0]  cmd_byteen = 16'hFFFF;

  logic rdy1, busy1, done1, rdy2, busy2, done2;
  logic [127:0] sig1, sig2;
  logic [11:0]  mc1, mc2;
  logic [10:0]  fe1, fe2;

  onchip_mem_test_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus1 ();
  onchip_mem_test_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus2 ();

  onchip_mem_test_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(1)) dut1 (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(rdy1), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_pattern(cmd_pattern), .cmd_byteen(cmd_byteen),
    .avm(bus1.master), .busy(busy1), .done(done1), .signature(sig1),
    .mismatch_cnt(mc1), .first_err_addr(fe1));

  onchip_mem_test_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(2)) dut2 (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(rdy2), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_pattern(cmd_pattern), .cmd_byteen(cmd_byteen),
    .avm(bus2.master), .busy(busy2), .done(done2), .signature(sig2),
    .mismatch_cnt(mc2), .first_err_addr(fe2));

  // RAM models plus bench-side poke/clear port
  logic [127:0] mem1 [NW];
  logic [127:0] mem2 [NW];
  logic [127:0] rd2_a;
  logic         poke_en = 1'b0;
  logic         clr_en = 1'b1;
  logic [10:0]  poke_a = 11'd0;
  logic [127:0] poke_d = 128'd0;

  always @(posedge clk) begin
    if (clr_en) begin
      for (int i = 0; i < NW; i++) begin
        mem1[i] <= 128'd0;
        mem2[i] <= 128'd0;
      end
    end
    if (poke_en) begin
      mem1[poke_a] <= poke_d;
      mem2[poke_a] <= poke_d;
    end
    if (bus1.avm_chipselect && bus1.avm_write) begin
      for (int b = 0; b < 16; b++)
        if (bus1.avm_byteenable[b]) mem1[bus1.avm_address][b*8 +: 8] <= bus1.avm_writedata[b*8 +: 8];
    end
    if (bus1.avm_chipselect && !bus1.avm_write) bus1.avm_readdata <= mem1[bus1.avm_address];
    if (bus2.avm_chipselect && bus2.avm_write) begin
      for (int b = 0; b < 16; b++)
        if (bus2.avm_byteenable[b]) mem2[bus2.avm_address][b*8 +: 8] <= bus2.avm_writedata[b*8 +: 8];
    end
    if (bus2.avm_chipselect && !bus2.avm_write) rd2_a <= mem2[bus2.avm_address];
    bus2.avm_readdata <= rd2_a;
  end

  // Bus monitor: access totals and a log of instance-1 writes
  int cs1_tot = 0, cs2_tot = 0, wr_tot = 0;
  logic [10:0]  wa [RING];
  logic [127:0] wd [RING];
  logic [15:0]  wb [RING];

  always @(posedge clk) begin
    if (bus1.avm_chipselect) cs1_tot <= cs1_tot + 1;
    if (bus2.avm_chipselect) cs2_tot <= cs2_tot + 1;
    if (bus1.avm_chipselect && bus1.avm_write) begin
      wa[wr_tot % RING] <= bus1.avm_address;
      wd[wr_tot % RING] <= bus1.avm_writedata;
      wb[wr_tot % RING] <= bus1.avm_byteenable;
      wr_tot <= wr_tot + 1;
    end
  end

  // Reference model state
  logic [127:0] ref_mem [NW];
  logic [127:0] exp_sig = 128'd0;
  logic [11:0]  exp_mc = 12'd0;
  logic [10:0]  exp_fe = 11'd0;
  int n_chk = 0, n_pass = 0;
  int last_w0 = 0;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [127:0] bmask(input logic [15:0] be);
    logic [127:0] m;
    for (int b = 0; b < 16; b++) m[b*8 +: 8] = {8{be[b]}};
    return m;
  endfunction

  function automatic logic [15:0] eff_be(input logic [15:0] be);
`ifdef ONCHIP_MASTER_BYTEMASK_EN
    return be;
`else
    return 16'hFFFF;
`endif
  endfunction

  task automatic poke(input logic [10:0] a, input logic [127:0] d);
    @(negedge clk);
    poke_a = a; poke_d = d; poke_en = 1'b1;
    ref_mem[a] = d;
    @(negedge clk);
    poke_en = 1'b0;
  endtask

  task automatic check_status(input string tag);
    check_eq({tag, "_sig1"}, sig1, exp_sig);
    check_eq({tag, "_mc1"}, 128'(mc1), 128'(exp_mc));
    check_eq({tag, "_fe1"}, 128'(fe1), 128'(exp_fe));
    check_eq({tag, "_stat2"}, {sig2, 5'd0, mc2, fe2}, {exp_sig, 5'd0, exp_mc, exp_fe});
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_ctl1"}, {rdy1, busy1, done1, bus1.avm_chipselect, bus1.avm_write, bus1.avm_clken},
             {6'b100001});
    check_eq({tag, "_addr1"}, 128'(bus1.avm_address), 128'd0);
    check_eq({tag, "_wdata1"}, bus1.avm_writedata, 128'd0);
    check_eq({tag, "_be1"}, 128'(bus1.avm_byteenable), 128'hFFFF);
    check_eq({tag, "_ctl2"}, {rdy2, busy2, done2, bus2.avm_chipselect, bus2.avm_write, bus2.avm_clken,
             bus2.avm_address, bus2.avm_byteenable}, {6'b100001, 11'd0, 16'hFFFF});
    check_status(tag);
  endtask

  task automatic run_cmd(input logic op, input logic [10:0] a, input logic [11:0] n,
                         input logic [127:0] p, input logic [15:0] be, input string tag);
    int c1_0, c2_0, w0, lat1, lat2, bad, el1, el2;
    logic [15:0] ebe;
    logic [127:0] m, w, rd, s;
    logic [10:0] ad, fe;
    logic [11:0] mc;
    @(negedge clk);
    check_eq({tag, "_ready"}, 128'(rdy1 & rdy2), 128'd1);
    cmd_op = op; cmd_addr = a; cmd_len = n; cmd_pattern = p; cmd_byteen = be; cmd_valid = 1'b1;
    c1_0 = cs1_tot; c2_0 = cs2_tot; w0 = wr_tot; last_w0 = w0;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    lat1 = 0; lat2 = 0;
    for (int c = 1; c <= 2200 && (lat1 == 0 || lat2 == 0); c++) begin
      @(negedge clk);
      if (done1 && lat1 == 0) lat1 = c;
      if (done2 && lat2 == 0) lat2 = c;
    end
    el1 = (n == 12'd0) ? 1 : (op ? int'(n) + 2 : int'(n) + 1);
    el2 = (n == 12'd0) ? 1 : (op ? int'(n) + 3 : int'(n) + 1);
    check_eq({tag, "_lat1"}, 128'(lat1), 128'(el1));
    check_eq({tag, "_lat2"}, 128'(lat2), 128'(el2));
    @(negedge clk);
    check_eq({tag, "_idle"}, {done1, done2, busy1, busy2, rdy1, rdy2}, 6'b000011);
    check_eq({tag, "_cs"}, {64'(cs1_tot - c1_0), 64'(cs2_tot - c2_0)}, {64'(n), 64'(n)});
    ebe = eff_be(be);
    m = bmask(ebe);
    if (!op) begin
      check_eq({tag, "_wcnt"}, 128'(wr_tot - w0), 128'(n));
      bad = 0;
      for (int i = 0; i < int'(n); i++) begin
        ad = a + 11'(i);
        w  = p + 128'(i);
        if (wa[(w0 + i) % RING] !== ad || wd[(w0 + i) % RING] !== w || wb[(w0 + i) % RING] !== ebe) bad++;
        ref_mem[ad] = (ref_mem[ad] & ~m) | (w & m);
      end
      check_eq({tag, "_wbad"}, 128'(bad), 128'd0);
    end else begin
      s = 128'd0; mc = 12'd0; fe = 11'd0;
      for (int i = 0; i < int'(n); i++) begin
        ad = a + 11'(i);
        rd = ref_mem[ad];
        s  = s ^ rd;
        if (((rd ^ (p + 128'(i))) & m) != 128'd0) begin
          if (mc == 12'd0) fe = ad;
          mc = mc + 12'd1;
        end
      end
      exp_sig = s; exp_mc = mc; exp_fe = fe;
    end
    check_status(tag);
  endtask

  initial begin
    logic         op;
    logic [10:0]  a, fa;
    logic [11:0]  n, fn;
    logic [127:0] p, fp, rp;
    logic [15:0]  be;
    int w0;

    for (int i = 0; i < NW; i++) ref_mem[i] = 128'd0;
    fa = 11'd0; fn = 12'd1; fp = 128'd0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check_reset_vals("rst0");
    clr_en = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    check_reset_vals("rst0_rel");

    // Wrap-around FILL and CHECK of the same range
    run_cmd(1'b0, 11'h7FE, 12'd4, 128'h10, 16'hFFFF, "tp_fill");
    check_eq("tp_fill_wa", {wa[last_w0], wa[last_w0+1], wa[last_w0+2], wa[last_w0+3]},
             {11'h7FE, 11'h7FF, 11'h000, 11'h001});
    check_eq("tp_fill_wd3", wd[last_w0+3], 128'h13);
    run_cmd(1'b1, 11'h7FE, 12'd4, 128'h10, 16'hFFFF, "tp_check");
    check_eq("tp_check_res", {sig1, mc1}, {128'h0, 12'd0});

    // Corrupted word
    poke(11'h000, 128'hFF);
    run_cmd(1'b1, 11'h7FE, 12'd4, 128'h10, 16'hFFFF, "tp_corrupt");
    check_eq("tp_corrupt_res", {mc1, fe1}, {12'd1, 11'h000});

    // Zero-length commands
    run_cmd(1'b0, 11'h123, 12'd0, 128'h55, 16'hFFFF, "len0_fill");
    run_cmd(1'b1, 11'h123, 12'd0, 128'h55, 16'hFFFF, "len0_check");

    // Randomised commands, CHECKs often replay the last FILL
    for (int t = 0; t < 14; t++) begin
      op = 1'($urandom_range(0, 1));
      a  = 11'($urandom);
      n  = ($urandom_range(0, 7) == 0) ? 12'd0 : 12'($urandom_range(1, 48));
      p  = {$urandom, $urandom, $urandom, $urandom};
      be = 16'($urandom);
      if (op && $urandom_range(0, 2) != 0) begin
        a = fa; n = fn; p = fp;
        if ($urandom_range(0, 1) == 1) begin
          rp = {$urandom, $urandom, $urandom, $urandom};
          poke(fa + 11'($urandom_range(0, int'(fn) - 1)), rp);
        end
      end
      if (!op && n != 12'd0) begin
        fa = a; fn = n; fp = p;
      end
      run_cmd(op, a, n, p, be, $sformatf("rnd%0d", t));
    end

    // Full-size CHECK over the whole RAM
    run_cmd(1'b1, 11'($urandom), 12'd2048, {$urandom, $urandom, $urandom, $urandom}, 16'hFFFF, "full_check");

    // Byte-masked FILL then CHECK with the same mask
    p = {$urandom, $urandom, $urandom, $urandom};
    poke(11'h300, ~p);
    run_cmd(1'b0, 11'h300, 12'd8, p, 16'h0001, "bm_fill");
    check_eq("bm_fill_be", 128'(wb[last_w0]), 128'(eff_be(16'h0001)));
    run_cmd(1'b1, 11'h300, 12'd8, p, 16'h0001, "bm_check");
    check_eq("bm_check_mc", 128'(mc1), 128'd0);

    // Reset in the middle of a full-size FILL
    p = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    cmd_op = 1'b0; cmd_addr = 11'd0; cmd_len = 12'd2048; cmd_pattern = p; cmd_byteen = 16'hFFFF;
    cmd_valid = 1'b1;
    w0 = wr_tot;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    for (int c = 0; c < 300 && (wr_tot - w0) < 100; c++) @(negedge clk);
    check_eq("rst_mid_wcnt", 128'(wr_tot - w0), 128'd100);
    reset = 1'b1;
    #1;
    for (int i = 0; i < 100; i++) ref_mem[i] = p + 128'(i);
    exp_sig = 128'd0; exp_mc = 12'd0; exp_fe = 11'd0;
    check_reset_vals("rst_mid");
    repeat (3) @(negedge clk);
    check_eq("rst_mid_noacc", 128'(wr_tot - w0), 128'd100);
    reset = 1'b0;
    @(negedge clk);
    run_cmd(1'b1, 11'd0, 12'd100, p, 16'hFFFF, "post_rst");
    check_eq("post_rst_mc", 128'(mc1), 128'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
